// File: rtl/servo_pwm_if.sv
// Servo PWM array bundle: command/enable inputs from the control path and
// frame-synchronous pulse outputs toward the servo/ESC pins.
interface servo_pwm_if #(
   parameter int N_CH = 3,
   parameter int W    = 11
);
   logic [N_CH*W-1:0] cmd_us;
   logic [N_CH-1:0]   cmd_valid;
   logic [N_CH-1:0]   ch_en;
   logic              safe_stop;
   logic [N_CH-1:0]   pwm;
   logic [N_CH*W-1:0] cur_us;
   logic              frame_start;

   modport master (
      output cmd_us, cmd_valid, ch_en, safe_stop,
      input  pwm, cur_us, frame_start
   );

   modport slave (
      input  cmd_us, cmd_valid, ch_en, safe_stop,
      output pwm, cur_us, frame_start
   );
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: shared microsecond prescaler and frame
// counter, per-channel clamped targets, per-frame slew limiting and safe-stop.
module servo_pwm_array #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int N_CH        = 3,
   parameter int W           = 11,
   parameter int FRAME_US    = 20000,
   parameter int MIN_US      = 1000,
   parameter int MAX_US      = 2000,
   parameter int NEUTRAL_US  = 1500,
   parameter int SLEW_US     = 10
) (
   input logic        clk,
   input logic        rst,
   servo_pwm_if.slave bus
);

   localparam int DIV = CLK_FREQ_HZ / 1_000_000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(FRAME_US);
   localparam int XW  = CW + W;
   localparam logic signed [W:0] SLEW_S = (W+1)'(SLEW_US);

   logic [PW-1:0]             pre_cnt;
   logic [CW-1:0]             us_cnt;
   logic                      us_tick;
   logic                      wrap;
   logic                      frame_start_q;
   logic [N_CH-1:0][W-1:0]    tgt;
   logic [N_CH-1:0][W-1:0]    cur;
   logic [N_CH-1:0]           en_lat;
   logic [N_CH-1:0]           pwm_q;

   function automatic logic [W-1:0] clamp_us(input logic [W-1:0] v);
      logic [W-1:0] res;
      res = v;
      if (v < W'(MIN_US))
         res = W'(MIN_US);
      else if (v > W'(MAX_US))
         res = W'(MAX_US);
      return res;
   endfunction

   // Operands are already clamped, so the W+1 bit signed difference never wraps.
   function automatic logic [W-1:0] slew_step(input logic [W-1:0] from,
                                              input logic [W-1:0] to);
      logic signed [W:0] diff;
      logic [W-1:0]      res;
      diff = $signed({1'b0, to}) - $signed({1'b0, from});
      res  = to;
      if (SLEW_US != 0) begin
         if (diff > SLEW_S)
            res = from + W'(SLEW_US);
         else if (diff < -SLEW_S)
            res = from - W'(SLEW_US);
      end
      return res;
   endfunction

   assign us_tick = (pre_cnt == PW'(DIV - 1));
   assign wrap    = us_tick && (us_cnt == CW'(FRAME_US - 1));

   // Timebase: microsecond prescaler and frame counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt       <= '0;
         us_cnt        <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pre_cnt       <= us_tick ? '0 : pre_cnt + PW'(1);
         if (us_tick)
            us_cnt <= wrap ? '0 : us_cnt + CW'(1);
         frame_start_q <= wrap;
      end
   end

   // Per-channel state: targets capture any time, applied width and enable move
   // only on the wrap edge, where us_cnt >= cur keeps pwm low and avoids runts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) begin
            tgt[i] <= W'(NEUTRAL_US);
            cur[i] <= W'(NEUTRAL_US);
         end
         en_lat <= '0;
         pwm_q  <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.cmd_valid[i])
               tgt[i] <= clamp_us(bus.cmd_us[i*W +: W]);
            if (wrap) begin
               cur[i]    <= slew_step(cur[i], bus.safe_stop ? W'(NEUTRAL_US) : tgt[i]);
               en_lat[i] <= bus.ch_en[i];
            end
            pwm_q[i] <= en_lat[i] && ({{W{1'b0}}, us_cnt} < XW'({{CW{1'b0}}, cur[i]}));
         end
      end
   end

   assign bus.pwm         = pwm_q;
   assign bus.cur_us      = cur;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array: a slew-limited instance and a no-slew
// instance share clock and reset, so their frames stay aligned.
module tb_servo_pwm_array;

   localparam int CLK_HZ = 2_000_000;
   localparam int N      = 3;
   localparam int WW     = 11;
   localparam int FUS    = 64;
   localparam int MINU   = 10;
   localparam int MAXU   = 40;
   localparam int NEU    = 25;
   localparam int DIV    = 2;
   localparam int FR     = FUS * DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   hi  [N];
   int   hi0 [N];
   int   fs_cnt;
   logic fs_end;

   servo_pwm_if #(.N_CH(N), .W(WW)) bus ();
   servo_pwm_if #(.N_CH(N), .W(WW)) bus0 ();

   servo_pwm_array #(
      .CLK_FREQ_HZ(CLK_HZ), .N_CH(N), .W(WW), .FRAME_US(FUS), .MIN_US(MINU),
      .MAX_US(MAXU), .NEUTRAL_US(NEU), .SLEW_US(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   servo_pwm_array #(
      .CLK_FREQ_HZ(CLK_HZ), .N_CH(N), .W(WW), .FRAME_US(FUS), .MIN_US(MINU),
      .MAX_US(MAXU), .NEUTRAL_US(NEU), .SLEW_US(0)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int cur_of(input int dev, input int ch);
      if (dev == 0)
         return int'(bus.cur_us[ch*WW +: WW]);
      return int'(bus0.cur_us[ch*WW +: WW]);
   endfunction

   // Starts on the negedge of a frame_start cycle, ends on the next one.
   task automatic measure_frame();
      for (int c = 0; c < N; c++) begin
         hi[c]  = 0;
         hi0[c] = 0;
      end
      fs_cnt = 0;
      for (int k = 0; k < FR; k++) begin
         for (int c = 0; c < N; c++) begin
            hi[c]  += int'(bus.pwm[c]);
            hi0[c] += int'(bus0.pwm[c]);
         end
         fs_cnt += int'(bus.frame_start);
         @(negedge clk);
      end
      fs_end = bus.frame_start;
   endtask

   task automatic drive_cmd(input int dev, input int ch, input int val);
      if (dev == 0) begin
         bus.cmd_us[ch*WW +: WW] = WW'(val);
         bus.cmd_valid[ch]       = 1'b1;
      end else begin
         bus0.cmd_us[ch*WW +: WW] = WW'(val);
         bus0.cmd_valid[ch]       = 1'b1;
      end
      @(negedge clk);
      if (dev == 0) bus.cmd_valid[ch] = 1'b0;
      else          bus0.cmd_valid[ch] = 1'b0;
   endtask

   task automatic wait_first_frame(output int cnt, output int pwm_hi);
      cnt    = 0;
      pwm_hi = 0;
      for (int k = 0; k < 4*FR; k++) begin
         @(negedge clk);
         cnt++;
         if (bus.frame_start) break;
         if (bus.pwm != '0 || bus0.pwm != '0) pwm_hi++;
      end
   endtask

   task automatic test_reset();
      int cnt, phi;
      bus.cmd_us = '0;  bus.cmd_valid = '0;  bus.ch_en = '1;  bus.safe_stop = 1'b0;
      bus0.cmd_us = '0; bus0.cmd_valid = '0; bus0.ch_en = '1; bus0.safe_stop = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.pwm !== 3'b000 || bus0.pwm !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_pwm: got %b/%b, want 000/000", bus.pwm, bus0.pwm);
      end
      vectors++;
      if (bus.frame_start !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_frame_start: got %b, want 0", bus.frame_start);
      end
      for (int c = 0; c < N; c++) begin
         vectors++;
         if (cur_of(0, c) != NEU || cur_of(1, c) != NEU) begin
            miscompares++;
            $display("FAIL reset_cur ch%0d: got %0d/%0d, want %0d", c, cur_of(0, c), cur_of(1, c), NEU);
         end
      end
      rst = 1'b1;
      wait_first_frame(cnt, phi);
      vectors++;
      if (cnt != FR) begin
         miscompares++;
         $display("FAIL first_frame_latency: got %0d clks, want %0d", cnt, FR);
      end
      vectors++;
      if (phi != 0) begin
         miscompares++;
         $display("FAIL pwm_before_first_frame: got %0d high cycles, want 0", phi);
      end
      measure_frame();
      for (int c = 0; c < N; c++) begin
         vectors++;
         if (hi[c] != 2*NEU || hi0[c] != 2*NEU) begin
            miscompares++;
            $display("FAIL neutral_width ch%0d: got %0d/%0d, want %0d", c, hi[c], hi0[c], 2*NEU);
         end
      end
      vectors++;
      if (fs_end !== 1'b1 || fs_cnt != 1) begin
         miscompares++;
         $display("FAIL frame_period: got end=%b count=%0d, want end=1 count=1", fs_end, fs_cnt);
      end
   endtask

   task automatic test_slew();
      int exp_s [4] = '{31, 35, 39, 39};
      fork
         drive_cmd(0, 0, 27);
         measure_frame();
      join
      vectors++;
      if (hi[0] != 50) begin
         miscompares++;
         $display("FAIL capture_deferred: got %0d, want 50", hi[0]);
      end
      vectors++;
      if (cur_of(0, 0) != 27) begin
         miscompares++;
         $display("FAIL small_step_cur: got %0d, want 27", cur_of(0, 0));
      end
      fork
         drive_cmd(0, 0, 39);
         measure_frame();
      join
      vectors++;
      if (hi[0] != 54) begin
         miscompares++;
         $display("FAIL small_step_width: got %0d, want 54", hi[0]);
      end
      for (int f = 0; f < 4; f++) begin
         vectors++;
         if (cur_of(0, 0) != exp_s[f]) begin
            miscompares++;
            $display("FAIL slew_cur frame%0d: got %0d, want %0d", f, cur_of(0, 0), exp_s[f]);
         end
         measure_frame();
         vectors++;
         if (hi[0] != 2*exp_s[f]) begin
            miscompares++;
            $display("FAIL slew_width frame%0d: got %0d, want %0d", f, hi[0], 2*exp_s[f]);
         end
      end
   endtask

   task automatic test_clamp();
      fork
         drive_cmd(1, 0, 5);
         drive_cmd(1, 1, 2047);
         drive_cmd(0, 2, 2047);
         measure_frame();
      join
      vectors++;
      if (cur_of(1, 0) != MINU || cur_of(1, 1) != MAXU) begin
         miscompares++;
         $display("FAIL clamp_cur: got %0d/%0d, want %0d/%0d", cur_of(1, 0), cur_of(1, 1), MINU, MAXU);
      end
      vectors++;
      if (cur_of(0, 2) != 29) begin
         miscompares++;
         $display("FAIL clamp_slew_cur: got %0d, want 29", cur_of(0, 2));
      end
      // Command lands on the wrap edge itself.
      fork
         measure_frame();
         begin
            repeat (FR-1) @(negedge clk);
            drive_cmd(1, 0, 30);
         end
      join
      vectors++;
      if (hi0[0] != 20 || hi0[1] != 80 || hi[2] != 58) begin
         miscompares++;
         $display("FAIL clamp_width: got %0d/%0d/%0d, want 20/80/58", hi0[0], hi0[1], hi[2]);
      end
      vectors++;
      if (cur_of(1, 0) != MINU) begin
         miscompares++;
         $display("FAIL wrap_edge_cmd_old: got %0d, want %0d", cur_of(1, 0), MINU);
      end
      measure_frame();
      vectors++;
      if (hi0[0] != 20) begin
         miscompares++;
         $display("FAIL wrap_edge_cmd_width_old: got %0d, want 20", hi0[0]);
      end
      vectors++;
      if (cur_of(1, 0) != 30 || cur_of(0, 2) != 37) begin
         miscompares++;
         $display("FAIL wrap_edge_cmd_new: got %0d/%0d, want 30/37", cur_of(1, 0), cur_of(0, 2));
      end
      measure_frame();
      vectors++;
      if (hi0[0] != 60) begin
         miscompares++;
         $display("FAIL wrap_edge_cmd_width_new: got %0d, want 60", hi0[0]);
      end
   endtask

   task automatic test_enable();
      fork
         measure_frame();
         begin
            repeat (10) @(negedge clk);
            bus.ch_en[1] = 1'b0;
         end
      join
      vectors++;
      if (hi[1] != 50) begin
         miscompares++;
         $display("FAIL disable_completes_pulse: got %0d, want 50", hi[1]);
      end
      fork
         measure_frame();
         begin
            repeat (10) @(negedge clk);
            bus.ch_en[1] = 1'b1;
         end
      join
      vectors++;
      if (hi[1] != 0 || hi[0] != 78) begin
         miscompares++;
         $display("FAIL disabled_frame: got ch1=%0d ch0=%0d, want 0/78", hi[1], hi[0]);
      end
      measure_frame();
      vectors++;
      if (hi[1] != 50) begin
         miscompares++;
         $display("FAIL reenable_width: got %0d, want 50", hi[1]);
      end
   endtask

   task automatic test_safe_stop();
      int exp_c [10] = '{39, 35, 31, 27, 25, 25, 29, 33, 37, 37};
      for (int f = 0; f < 10; f++) begin
         vectors++;
         if (cur_of(0, 0) != exp_c[f]) begin
            miscompares++;
            $display("FAIL stop_cur frame%0d: got %0d, want %0d", f, cur_of(0, 0), exp_c[f]);
         end
         if (f == 0) bus.safe_stop = 1'b1;
         if (f == 5) bus.safe_stop = 1'b0;
         if (f == 1) begin
            vectors++;
            if (cur_of(0, 2) != 36) begin
               miscompares++;
               $display("FAIL stop_other_ch: got %0d, want 36", cur_of(0, 2));
            end
            fork
               drive_cmd(0, 0, 37);
               measure_frame();
            join
         end else begin
            measure_frame();
         end
         vectors++;
         if (hi[0] != 2*exp_c[f]) begin
            miscompares++;
            $display("FAIL stop_width frame%0d: got %0d, want %0d", f, hi[0], 2*exp_c[f]);
         end
      end
   endtask

   task automatic test_async_reset();
      int cnt, phi;
      repeat (10) @(negedge clk);
      vectors++;
      if (bus.pwm[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_pulse: got %b, want 1", bus.pwm[0]);
      end
      #3 rst = 1'b0;
      #1;
      vectors++;
      if (bus.pwm !== 3'b000 || bus0.pwm !== 3'b000 || bus.frame_start !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_outputs: got pwm %b/%b fs %b, want 000/000 fs 0", bus.pwm, bus0.pwm, bus.frame_start);
      end
      for (int c = 0; c < N; c++) begin
         vectors++;
         if (cur_of(0, c) != NEU || cur_of(1, c) != NEU) begin
            miscompares++;
            $display("FAIL async_reset_cur ch%0d: got %0d/%0d, want %0d", c, cur_of(0, c), cur_of(1, c), NEU);
         end
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_first_frame(cnt, phi);
      vectors++;
      if (cnt != FR || phi != 0) begin
         miscompares++;
         $display("FAIL restart_latency: got %0d clks, %0d high, want %0d clks, 0 high", cnt, phi, FR);
      end
      measure_frame();
      for (int c = 0; c < N; c++) begin
         vectors++;
         if (hi[c] != 2*NEU || hi0[c] != 2*NEU) begin
            miscompares++;
            $display("FAIL restart_width ch%0d: got %0d/%0d, want %0d", c, hi[c], hi0[c], 2*NEU);
         end
      end
   endtask

   initial begin
      test_reset();
      test_slew();
      test_clamp();
      test_enable();
      test_safe_stop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
